// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor with start/done handshake and carry/borrow chaining
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t               state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     a_r, b_r, res_next;
    logic [WIDTH+DIGIT-1:0] cat;
    logic                 s, c, c_msb_in, last;
    logic [DIGIT-1:0]     da, db;
    logic [DIGIT:0]       sum;
    // one digit of a + (b ^ s) + carry; the sum digit enters the result from the MSB side
    always_comb begin
        da       = a_r[DIGIT-1:0];
        db       = b_r[DIGIT-1:0] ^ {DIGIT{s}};
        sum      = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, c};
        c_msb_in = da[DIGIT-1] ^ db[DIGIT-1] ^ sum[DIGIT-1];
        cat      = {sum[DIGIT-1:0], result};
        res_next = cat[WIDTH+DIGIT-1:DIGIT];
        last     = cnt == CW'(N - 1);
    end
    // control, operand shift registers and registered flags; flags are captured on the last digit
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            s        <= 1'b0;
            c        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    a_r   <= a;
                    b_r   <= b;
                    s     <= op[0];
                    c     <= op[1] ? cin ^ op[0] : op[0];
                end
            end else begin
                a_r    <= a_r >> DIGIT;
                b_r    <= b_r >> DIGIT;
                c      <= sum[DIGIT];
                result <= res_next;
                cnt    <= cnt + CW'(1);
                if (last) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    cout     <= sum[DIGIT] ^ s;
                    overflow <= c_msb_in ^ sum[DIGIT];
                    zero     <= res_next == '0;
                    neg      <= res_next[WIDTH-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: randomized and directed checks of addsub_serial (16/4 and 8/8) against an arithmetic reference model
module tb_addsub_serial;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0, b = '0;
    logic        busy0, done0, cout0, ov0, z0, n0;
    logic [15:0] res0;
    logic        busy1, done1, cout1, ov1, z1, n1;
    logic [7:0]  res1;
    int          checks = 0, failures = 0;
    logic [15:0] g_r;
    logic        g_co, g_ov, g_z, g_n;

    typedef struct {
        longint r;
        bit     co, ov, z, n;
    } exp_t;

    typedef struct {
        logic [15:0] a, b;
        logic [1:0]  op;
        logic        cin;
        logic [15:0] r;
        logic        co, ov, z, n;
    } vec_t;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a), .b(b),
        .busy(busy0), .done(done0), .result(res0), .cout(cout0), .overflow(ov0), .zero(z0), .neg(n0)
    );

    addsub_serial #(.WIDTH(8), .DIGIT(8)) u1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin), .a(a[7:0]), .b(b[7:0]),
        .busy(busy1), .done(done1), .result(res1), .cout(cout1), .overflow(ov1), .zero(z1), .neg(n1)
    );

    always #5 clk = ~clk;

    // w-bit result of a +/- b +/- carry-in, computed with wide signed integers
    function automatic exp_t model(input int w, input logic [1:0] o, input logic ci, input longint x, input longint y);
        exp_t   e;
        longint m = (64'sd1 <<< w) - 1;
        longint half = 64'sd1 <<< (w - 1);
        longint k = longint'(o[1] & ci);
        longint sx, sy, full, sr;
        x  = x & m;
        y  = y & m;
        sx = x >= half ? x - m - 1 : x;
        sy = y >= half ? y - m - 1 : y;
        full = o[0] ? x - y - k : x + y + k;
        sr   = o[0] ? sx - sy - k : sx + sy + k;
        e.co = o[0] ? (x < y + k) : (full > m);
        e.ov = (sr < -half) || (sr >= half);
        e.r  = full & m;
        e.z  = e.r == 0;
        e.n  = ((e.r >> (w - 1)) & 1) != 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int w, input exp_t e,
                           input logic [15:0] r, input logic co, ov, z, n);
        chk({tag, "_res"}, r, e.r);
        chk({tag, "_cout"}, co, e.co);
        chk({tag, "_ovf"}, ov, e.ov);
        chk({tag, "_zero"}, z, e.z);
        chk({tag, "_neg"}, n, e.n);
    endtask

    // one operation on both instances; operands are scrambled right after accept
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic [1:0] top, input logic tc);
        exp_t e0, e1;
        int   lat0 = 0, lat1 = 0, nd0 = 0, nd1 = 0;
        e0 = model(16, top, tc, longint'(ta), longint'(tb_));
        e1 = model(8, top, tc, longint'(ta), longint'(tb_));
        a = ta; b = tb_; op = top; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); cin = 1'($urandom);
        chk("busy0_accept", busy0, 1);
        chk("busy1_accept", busy1, 1);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            chk("busy0_run", busy0, i < 4);
            chk("busy1_run", busy1, 0);
            if (done0) begin
                nd0++; lat0 = i;
                g_r = res0; g_co = cout0; g_ov = ov0; g_z = z0; g_n = n0;
                chk_out("w16", 16, e0, res0, cout0, ov0, z0, n0);
            end
            if (done1) begin
                nd1++; lat1 = i;
                chk_out("w8", 8, e1, {8'h00, res1}, cout1, ov1, z1, n1);
            end
            a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); cin = 1'($urandom);
        end
        chk("latency16", lat0, 4);
        chk("latency8", lat1, 1);
        chk("done16_pulses", nd0, 1);
        chk("done8_pulses", nd1, 1);
    endtask

    vec_t vecs[6] = '{
        '{16'h7FFF, 16'h0001, 2'b00, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1},
        '{16'h0003, 16'h0005, 2'b01, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1},
        '{16'h8000, 16'h0001, 2'b01, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 2'b10, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0},
        '{16'h0000, 16'h0000, 2'b11, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1},
        '{16'h1234, 16'h1234, 2'b01, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}
    };

    logic [15:0] ha[16], hb[16];
    logic [1:0]  ho[16];
    logic        hc[16];

    initial begin
        exp_t e;
        int   nd;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_res", res0, 0);
        chk("reset_flags", {cout0, ov0, z0, n0}, 0);
        start = 1'b1;
        @(posedge clk); #1;
        chk("reset_beats_start", busy0, 0);
        start = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin);
            chk("dir_res", g_r, vecs[i].r);
            chk("dir_cout", g_co, vecs[i].co);
            chk("dir_ovf", g_ov, vecs[i].ov);
            chk("dir_zero", g_z, vecs[i].z);
            chk("dir_neg", g_n, vecs[i].n);
        end
        // start held high with operands changing every cycle
        for (int c = 0; c < 16; c++) begin
            ha[c] = 16'($urandom); hb[c] = 16'($urandom); ho[c] = 2'($urandom); hc[c] = 1'($urandom);
            a = ha[c]; b = hb[c]; op = ho[c]; cin = hc[c]; start = 1'b1;
            @(posedge clk); #1;
            chk("hs_done16", done0, c % 5 == 4);
            chk("hs_done8", done1, c % 2 == 1);
            if (c % 5 == 4) begin
                e = model(16, ho[c-4], hc[c-4], longint'(ha[c-4]), longint'(hb[c-4]));
                chk_out("hs16", 16, e, res0, cout0, ov0, z0, n0);
            end
            if (c % 2 == 1) begin
                e = model(8, ho[c-1], hc[c-1], longint'(ha[c-1]), longint'(hb[c-1]));
                chk_out("hs8", 8, e, {8'h00, res1}, cout1, ov1, z1, n1);
            end
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        // abort two cycles after accept
        a = 16'h7FFF; b = 16'h7FFF; op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {busy0, busy1}, 0);
        chk("abort_done", {done0, done1}, 0);
        chk("abort_res16", res0, 0);
        chk("abort_res8", res1, 0);
        chk("abort_flags", {cout0, ov0, z0, n0, cout1, ov1, z1, n1}, 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            nd += int'(done0) + int'(done1);
        end
        chk("abort_no_done", nd, 0);
        run_op(16'h0001, 16'h0001, 2'b00, 1'b0);
        chk("after_abort_res", g_r, 16'h0002);
        for (int i = 0; i < 4000; i++)
            run_op(16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
